// File: rtl/ct_had_pcfifo_pkg.sv
// Shared types and sizing for the HAD PC change-flow FIFO controller.
package ct_had_pcfifo_pkg;

   localparam int unsigned DEPTH     = 16;
   localparam int unsigned CNT_WIDTH = 5;
   localparam int unsigned SLOTS     = 4;
   localparam int unsigned ADD_W     = 3;
   localparam int unsigned NXT_W     = CNT_WIDTH + 1;

   typedef enum logic [4:0] {
      ST_IDLE     = 5'b00001,
      ST_REC      = 5'b00010,
      ST_FRZ      = 5'b00100,
      ST_RD_ISSUE = 5'b01000,
      ST_RD_RSP   = 5'b10000
   } pcfifo_state_e;

   // Number of retire slots reporting a change-flow this cycle.
   function automatic logic [ADD_W-1:0] popcount_slots(input logic [SLOTS-1:0] v);
      logic [ADD_W-1:0] s;
      s = '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
         s = s + ADD_W'(v[i]);
      end
      return s;
   endfunction

endpackage

// File: rtl/ct_had_pcfifo_cnt.sv
// Occupancy mirror of the PC FIFO: delayed write accounting, saturation at
// DEPTH and a sticky overflow flag.
module ct_had_pcfifo_cnt
   import ct_had_pcfifo_pkg::*;
(
   input  logic                 cpuclk,
   input  logic                 cpurst_b,
   input  logic                 i_wen,
   input  logic [SLOTS-1:0]     i_chgflow,
   input  logic                 i_ren,
   input  logic                 i_ovf_clr,
   output logic [CNT_WIDTH-1:0] o_cnt,
   output logic                 o_empty,
   output logic                 o_ovf
);

   logic [ADD_W-1:0]     r_add;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_empty;
   logic                 r_ovf;
   logic [NXT_W-1:0]     w_nxt;
   logic                 w_dec;
   logic                 w_over;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;

   // One extra bit keeps cnt + 4 from wrapping before the saturation test.
   always_comb begin
      w_dec     = i_ren & (r_cnt != '0);
      w_nxt     = {1'b0, r_cnt} + NXT_W'(r_add) - NXT_W'(w_dec);
      w_over    = (w_nxt > NXT_W'(DEPTH));
      w_cnt_nxt = w_over ? CNT_WIDTH'(DEPTH) : CNT_WIDTH'(w_nxt);
   end

   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_add   <= '0;
         r_cnt   <= '0;
         r_empty <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         r_add   <= i_wen ? popcount_slots(i_chgflow) : '0;
         r_cnt   <= w_cnt_nxt;
         r_empty <= (w_cnt_nxt == '0);
         if (w_over) begin
            r_ovf <= 1'b1;
         end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign o_cnt   = r_cnt;
   assign o_empty = r_empty;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/ct_had_pcfifo_ctrl.sv
// HAD PC-FIFO controller: record/freeze write policy, read handshake toward
// the register block, and occupancy/overflow status.
module ct_had_pcfifo_ctrl
   import ct_had_pcfifo_pkg::*;
(
   input  logic                 cpuclk,
   input  logic                 cpurst_b,
   input  logic                 regs_ctrl_pcfifo_en,
   input  logic                 had_core_dbg_mode,
   input  logic                 rtu_had_xx_pcfifo_inst0_chgflow,
   input  logic                 rtu_had_xx_pcfifo_inst1_chgflow,
   input  logic                 rtu_had_xx_pcfifo_inst2_chgflow,
   input  logic                 rtu_had_xx_pcfifo_inst3_chgflow,
   input  logic                 regs_ctrl_pcfifo_rd_req,
   input  logic                 regs_ctrl_pcfifo_ovf_clr,
   output logic                 ctrl_regs_pcfifo_rd_rdy,
   output logic                 ctrl_regs_pcfifo_rdata_vld,
   output logic                 ctrl_pcfifo_wen,
   output logic                 ctrl_pcfifo_ren,
   output logic [CNT_WIDTH-1:0] ctrl_regs_pcfifo_cnt,
   output logic                 ctrl_regs_pcfifo_empty,
   output logic                 ctrl_regs_pcfifo_ovf
);

   pcfifo_state_e    r_state;
   pcfifo_state_e    w_state_nxt;
   logic             w_rd_acc;
   logic             w_wen;
   logic [SLOTS-1:0] w_chgflow;

   assign w_chgflow = {rtu_had_xx_pcfifo_inst3_chgflow, rtu_had_xx_pcfifo_inst2_chgflow,
                       rtu_had_xx_pcfifo_inst1_chgflow, rtu_had_xx_pcfifo_inst0_chgflow};

   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // An accepted read preempts record/freeze changes; writes stop while reading.
   always_comb begin
      w_state_nxt = r_state;
      w_rd_acc    = regs_ctrl_pcfifo_rd_req & ctrl_regs_pcfifo_rd_rdy;
      w_wen       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rd_acc)
               w_state_nxt = ST_RD_ISSUE;
            else if (regs_ctrl_pcfifo_en && !had_core_dbg_mode)
               w_state_nxt = ST_REC;
         end
         ST_REC: begin
            w_wen = regs_ctrl_pcfifo_en & ~had_core_dbg_mode;
            if (w_rd_acc)
               w_state_nxt = ST_RD_ISSUE;
            else if (!regs_ctrl_pcfifo_en)
               w_state_nxt = ST_IDLE;
            else if (had_core_dbg_mode)
               w_state_nxt = ST_FRZ;
         end
         ST_FRZ: begin
            if (w_rd_acc)
               w_state_nxt = ST_RD_ISSUE;
            else if (!regs_ctrl_pcfifo_en)
               w_state_nxt = ST_IDLE;
            else if (!had_core_dbg_mode)
               w_state_nxt = ST_REC;
         end
         ST_RD_ISSUE: w_state_nxt = ST_RD_RSP;
         ST_RD_RSP: begin
            if (!regs_ctrl_pcfifo_en)
               w_state_nxt = ST_IDLE;
            else if (had_core_dbg_mode)
               w_state_nxt = ST_FRZ;
            else
               w_state_nxt = ST_REC;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign ctrl_pcfifo_wen            = w_wen;
   assign ctrl_pcfifo_ren            = (r_state == ST_RD_ISSUE);
   assign ctrl_regs_pcfifo_rdata_vld = (r_state == ST_RD_RSP);
   assign ctrl_regs_pcfifo_rd_rdy    = (r_state == ST_IDLE) | (r_state == ST_REC) |
                                       (r_state == ST_FRZ);

   ct_had_pcfifo_cnt u_cnt (
      .cpuclk    (cpuclk),
      .cpurst_b  (cpurst_b),
      .i_wen     (w_wen),
      .i_chgflow (w_chgflow),
      .i_ren     (ctrl_pcfifo_ren),
      .i_ovf_clr (regs_ctrl_pcfifo_ovf_clr),
      .o_cnt     (ctrl_regs_pcfifo_cnt),
      .o_empty   (ctrl_regs_pcfifo_empty),
      .o_ovf     (ctrl_regs_pcfifo_ovf)
   );

endmodule

// File: tb/tb_ct_had_pcfifo_ctrl.sv
// Directed bench for ct_had_pcfifo_ctrl: reset, record, freeze, read
// handshake, overflow and read-while-recording.
module tb_ct_had_pcfifo_ctrl;

   logic       cpuclk;
   logic       cpurst_b;
   logic       en;
   logic       dbg;
   logic [3:0] chg;
   logic       rd_req;
   logic       ovf_clr;
   logic       rd_rdy;
   logic       vld;
   logic       wen;
   logic       ren;
   logic [4:0] cnt;
   logic       empty;
   logic       ovf;

   int n_checks = 0;
   int n_fail   = 0;

   ct_had_pcfifo_ctrl dut (
      .cpuclk                          (cpuclk),
      .cpurst_b                        (cpurst_b),
      .regs_ctrl_pcfifo_en             (en),
      .had_core_dbg_mode               (dbg),
      .rtu_had_xx_pcfifo_inst0_chgflow (chg[0]),
      .rtu_had_xx_pcfifo_inst1_chgflow (chg[1]),
      .rtu_had_xx_pcfifo_inst2_chgflow (chg[2]),
      .rtu_had_xx_pcfifo_inst3_chgflow (chg[3]),
      .regs_ctrl_pcfifo_rd_req         (rd_req),
      .regs_ctrl_pcfifo_ovf_clr        (ovf_clr),
      .ctrl_regs_pcfifo_rd_rdy         (rd_rdy),
      .ctrl_regs_pcfifo_rdata_vld      (vld),
      .ctrl_pcfifo_wen                 (wen),
      .ctrl_pcfifo_ren                 (ren),
      .ctrl_regs_pcfifo_cnt            (cnt),
      .ctrl_regs_pcfifo_empty          (empty),
      .ctrl_regs_pcfifo_ovf            (ovf)
   );

   initial cpuclk = 1'b0;
   always #5 cpuclk = ~cpuclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge (input drive point).
   task automatic tick();
      @(posedge cpuclk);
      #1;
   endtask

   // Let inputs settle, then sample mid-cycle.
   task automatic settle();
      #3;
   endtask

   initial begin
      cpurst_b = 1'b0; en = 1'b0; dbg = 1'b0; chg = 4'b0;
      rd_req = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_ren", 32'(ren), 32'd0);
      chk("rst_vld", 32'(vld), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_rdy", 32'(rd_rdy), 32'd1);

      // Read while empty: ren/vld still issued, cnt stays 0.
      cpurst_b = 1'b1;
      tick(); rd_req = 1'b1; settle();
      tick(); rd_req = 1'b0; settle();
      chk("empty_rd_ren", 32'(ren), 32'd1);
      tick(); settle();
      chk("empty_rd_vld", 32'(vld), 32'd1);
      chk("empty_rd_cnt", 32'(cnt), 32'd0);

      // Reset asserted while in RD_ISSUE.
      tick(); rd_req = 1'b1; settle();
      tick(); rd_req = 1'b0; settle();
      chk("t1_ren_pre", 32'(ren), 32'd1);
      cpurst_b = 1'b0; #1;
      chk("t1_ren", 32'(ren), 32'd0);
      chk("t1_rdy", 32'(rd_rdy), 32'd1);
      chk("t1_empty", 32'(empty), 32'd1);
      tick(); cpurst_b = 1'b1; settle();
      chk("t1_novld0", 32'(vld), 32'd0);
      tick(); settle();
      chk("t1_novld1", 32'(vld), 32'd0);

      // Record 4'b1011.
      tick(); en = 1'b1; settle();
      chk("t2_wen_idle", 32'(wen), 32'd0);
      tick(); chg = 4'b1011; settle();
      chk("t2_wen", 32'(wen), 32'd1);
      tick(); chg = 4'b0000; settle();
      chk("t2_cnt_lat", 32'(cnt), 32'd0);
      tick(); settle();
      chk("t2_cnt", 32'(cnt), 32'd3);
      chk("t2_empty", 32'(empty), 32'd0);

      // Freeze on debug entry; the same-cycle change-flow is dropped.
      tick(); dbg = 1'b1; chg = 4'b0001; settle();
      chk("t3_wen", 32'(wen), 32'd0);
      tick(); chg = 4'b0000; settle();
      chk("t3_frz_wen", 32'(wen), 32'd0);
      chk("t3_frz_rdy", 32'(rd_rdy), 32'd1);
      tick(); settle();
      chk("t3_cnt", 32'(cnt), 32'd3);

      // Read handshake from FRZ.
      tick(); rd_req = 1'b1; settle();
      tick(); rd_req = 1'b0; settle();
      chk("t4_ren", 32'(ren), 32'd1);
      chk("t4_rdy_n1", 32'(rd_rdy), 32'd0);
      chk("t4_vld_n1", 32'(vld), 32'd0);
      chk("t4_cnt_n1", 32'(cnt), 32'd3);
      tick(); settle();
      chk("t4_vld", 32'(vld), 32'd1);
      chk("t4_ren_n2", 32'(ren), 32'd0);
      chk("t4_rdy_n2", 32'(rd_rdy), 32'd0);
      chk("t4_cnt", 32'(cnt), 32'd2);
      tick(); settle();
      chk("t4_rdy_back", 32'(rd_rdy), 32'd1);
      chk("t4_frz_wen", 32'(wen), 32'd0);

      // Overflow: 2 + 4*4 + 2 saturates at 16.
      tick(); dbg = 1'b0; settle();
      for (int i = 0; i < 4; i++) begin
         tick(); chg = 4'b1111; settle();
         chk("t5_wen", 32'(wen), 32'd1);
      end
      tick(); chg = 4'b0011; settle();
      tick(); chg = 4'b0000; settle();
      chk("t5_cnt_sat", 32'(cnt), 32'd16);
      chk("t5_ovf", 32'(ovf), 32'd1);
      tick(); ovf_clr = 1'b1; settle();
      chk("t5_cnt_hold", 32'(cnt), 32'd16);
      tick(); ovf_clr = 1'b0; settle();
      chk("t5_ovf_clr", 32'(ovf), 32'd0);
      tick(); chg = 4'b0001; settle();
      tick(); chg = 4'b0000; ovf_clr = 1'b1; settle();
      tick(); ovf_clr = 1'b0; settle();
      chk("t5_set_wins", 32'(ovf), 32'd1);
      chk("t5_cnt_sat2", 32'(cnt), 32'd16);

      // Read while recording: change-flow during the read is not counted.
      tick(); rd_req = 1'b1; settle();
      chk("t6_wen_n", 32'(wen), 32'd1);
      tick(); rd_req = 1'b0; chg = 4'b0100; settle();
      chk("t6_wen_n1", 32'(wen), 32'd0);
      chk("t6_ren", 32'(ren), 32'd1);
      tick(); settle();
      chk("t6_wen_n2", 32'(wen), 32'd0);
      chk("t6_vld", 32'(vld), 32'd1);
      chk("t6_cnt_rd", 32'(cnt), 32'd15);
      tick(); chg = 4'b0000; settle();
      chk("t6_wen_rec", 32'(wen), 32'd1);
      chk("t6_rdy", 32'(rd_rdy), 32'd1);
      tick(); settle();
      chk("t6_cnt_final", 32'(cnt), 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ct_had_pcfifo_ctrl.md
Name: ct_had_pcfifo_ctrl

Overview:
Controller that sequences the HAD PC-change-flow FIFO (16 entries, 4 retire slots/cycle). It generates the FIFO write enable (record/freeze policy driven by HCR enable and debug-mode entry) and the FIFO read enable (a req/rdy handshake from the HAD register block). It keeps a mirror occupancy counter and a sticky overflow flag for the debug status register. It sits between the HAD register block (ct_had_regs), the HAD debug-mode control and the PC FIFO.

Parameters:
DEPTH, 16, FIFO entry count; must match the PC FIFO.
CNT_WIDTH, 5, occupancy counter width; holds 0..DEPTH.

Ports:
cpuclk  in  1  core clock
cpurst_b  in  1  async active-low reset
regs_ctrl_pcfifo_en  in  1  HCR PC-FIFO record enable, level
had_core_dbg_mode  in  1  core in debug mode, level
rtu_had_xx_pcfifo_inst0_chgflow  in  1  retire slot 0 change-flow
rtu_had_xx_pcfifo_inst1_chgflow  in  1  retire slot 1 change-flow
rtu_had_xx_pcfifo_inst2_chgflow  in  1  retire slot 2 change-flow
rtu_had_xx_pcfifo_inst3_chgflow  in  1  retire slot 3 change-flow
regs_ctrl_pcfifo_rd_req  in  1  read request, held until accepted
regs_ctrl_pcfifo_ovf_clr  in  1  clear sticky overflow, 1-cycle pulse
ctrl_regs_pcfifo_rd_rdy  out  1  ready to accept read
ctrl_regs_pcfifo_rdata_vld  out  1  FIFO dout valid, 1-cycle pulse
ctrl_pcfifo_wen  out  1  FIFO write enable
ctrl_pcfifo_ren  out  1  FIFO read enable, 1-cycle pulse
ctrl_regs_pcfifo_cnt  out  CNT_WIDTH  mirrored occupancy
ctrl_regs_pcfifo_empty  out  1  cnt==0
ctrl_regs_pcfifo_ovf  out  1  sticky overflow

Behaviour:
- Reset values: state IDLE; wen=0, ren=0, rdata_vld=0, cnt=0, empty=1, ovf=0. rd_rdy=1 in IDLE, so rd_rdy=1 out of reset.
- States: IDLE, REC, FRZ, RD_ISSUE, RD_RSP. Encoding is one-hot.
  - IDLE->REC when en & !dbg_mode.
  - REC->FRZ when dbg_mode. REC->IDLE when !en. !en has priority.
  - FRZ->REC when en & !dbg_mode. FRZ->IDLE when !en.
  - In IDLE/REC/FRZ, an accepted read (rd_req & rd_rdy) takes priority over all other transitions and goes to RD_ISSUE.
  - RD_ISSUE->RD_RSP unconditionally.
  - RD_RSP re-evaluates en/dbg_mode and goes to IDLE, REC or FRZ (REC if en & !dbg, FRZ if en & dbg, else IDLE).
- ctrl_pcfifo_wen is combinational: state==REC & en & !dbg_mode. It is 0 in all other states, so change-flow retired while a read is in progress is dropped. The drop is intentional: it gives a consistent snapshot.
- rd_rdy = state in {IDLE, REC, FRZ}.
- Read latency: request accepted in cycle N; ren=1 in N+1 (registered, state RD_ISSUE); rdata_vld=1 in N+2 (RD_RSP), aligned with the FIFO registered dout.
- A read while empty still issues ren; the FIFO returns the stale entry and cnt stays 0.
- Occupancy mirror tracks FIFO write timing:
  - Cycle N: add_q <= wen ? popcount(inst0..3 chgflow) : 0.
  - End of cycle N+1: add_q is applied.
  - Update: nxt = cnt + add_q - (ren & cnt!=0).
  - If nxt > DEPTH: cnt <= DEPTH and ovf <= 1 (entries were overwritten).
- ovf_clr clears ovf. A set in the same cycle wins over the clear.
- The add/ren arithmetic is done at CNT_WIDTH+1 bits to avoid wrap. Max nxt is 16+4=20.
- Deassertion of en does not clear cnt; FIFO contents persist.
- Reset mid-read: all state returns to reset values; no rdata_vld is issued.

Decomposition:
- Package ct_had_pcfifo_pkg holds:
  - the state localparams (IDLE, REC, FRZ, RD_ISSUE, RD_RSP);
  - DEPTH=16, CNT_WIDTH=5;
  - the slot count 4.
- Sub-module ct_had_pcfifo_cnt owns the occupancy counter:
  - popcount stage and add_q flop;
  - saturating update;
  - sticky ovf.
- The FSM and enables stay in the top module.

Test Plan:
1. Reset: cpurst_b low mid-RD_ISSUE -> wen=0, ren=0, cnt=0, empty=1, rd_rdy=1; no rdata_vld afterwards.
2. Record: en=1, dbg=0, chgflow=4'b1011 for 1 cycle -> wen=1 that cycle; cnt=3 two cycles later; empty=0.
3. Freeze: dbg_mode rises in cycle N with chgflow=4'b0001 -> wen=0 in N; cnt unchanged; state FRZ.
4. Read handshake: in FRZ with cnt=3, rd_req in N -> ren pulse in N+1, rdata_vld in N+2, cnt=2 after N+1, rd_rdy=0 in N+1..N+2.
5. Overflow: record 4 cycles of 4'b1111 plus 1 of 4'b0011 -> cnt saturates at 16, ovf=1; ovf_clr pulse -> ovf=0; a simultaneous set and clear leaves ovf=1.
6. Read while recording: in REC, rd_req with chgflow=4'b0100 active -> wen=0 in N+1 and N+2, and that slot's chgflow is not counted; after RD_RSP returns to REC, wen=1.
